// File: rtl/br_pred_resolve_if.sv
// br_pred_resolve_if: prediction carry, EX resolution inputs and mispredict/counter outputs
interface br_pred_resolve_if #(
  parameter int CNT_W = 32
);
  logic PRED_TAKEN;
  logic [31:0] NPC_PRED;
  logic stall_ID;
  logic flush_ID;
  logic stall_EX;
  logic flush_EX;
  logic br_inst;
  logic br;
  logic [31:0] br_target;
  logic [31:0] PC_EX;
  logic PRED_TAKEN_EX;
  logic mispredict;
  logic [31:0] NPC_FIX;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;
  modport master (
    output PRED_TAKEN, NPC_PRED, stall_ID, flush_ID, stall_EX, flush_EX,
    output br_inst, br, br_target, PC_EX,
    input PRED_TAKEN_EX, mispredict, NPC_FIX, br_cnt, miss_cnt
  );
  modport slave (
    input PRED_TAKEN, NPC_PRED, stall_ID, flush_ID, stall_EX, flush_EX,
    input br_inst, br, br_target, PC_EX,
    output PRED_TAKEN_EX, mispredict, NPC_FIX, br_cnt, miss_cnt
  );
endinterface

// File: rtl/br_pred_resolve.sv
// br_pred_resolve: carries IF predictions to EX, flags mispredicts and counts branches/misses
module br_pred_resolve #(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  br_pred_resolve_if.slave bus
);
  logic v_id, tk_id, v_ex, tk_ex, taken, miss, retire;
  logic [31:0] npc_id, npc_ex;
  logic [CNT_W-1:0] br_cnt, miss_cnt;
  always_comb begin
    taken = bus.br_inst & bus.br;
    miss = v_ex & ((taken & (!tk_ex | (npc_ex != bus.br_target))) | (tk_ex & !taken));
    retire = v_ex & !bus.stall_EX & !bus.flush_EX;
  end
  assign bus.PRED_TAKEN_EX = v_ex & tk_ex;
  assign bus.mispredict = miss;
  assign bus.NPC_FIX = (taken & miss) ? bus.br_target : bus.PC_EX + 32'd4;
  assign bus.br_cnt = br_cnt;
  assign bus.miss_cnt = miss_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_id <= 1'b0;
      tk_id <= 1'b0;
      npc_id <= '0;
      v_ex <= 1'b0;
      tk_ex <= 1'b0;
      npc_ex <= '0;
      br_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (bus.flush_ID) begin
        v_id <= 1'b0;
        tk_id <= 1'b0;
      end else if (!bus.stall_ID) begin
        v_id <= 1'b1;
        tk_id <= bus.PRED_TAKEN;
        npc_id <= bus.NPC_PRED;
      end
      if (bus.flush_EX) begin
        v_ex <= 1'b0;
        tk_ex <= 1'b0;
      end else if (!bus.stall_EX) begin
        v_ex <= v_id;
        tk_ex <= tk_id;
        npc_ex <= npc_id;
      end
      if (retire && bus.br_inst && br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      if (retire && miss && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
    end
endmodule
